// File: rtl/pipe_hazard_pkg.sv
// Shared types for the five-stage pipeline hazard controller: operand mux selects,
// scoreboard states and the forwarding priority helper.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // The youngest producer (M) wins over the older one (W).
    function automatic fwd_sel_e fwd_pick(input logic hit_m, input logic hit_w);
        fwd_sel_e sel;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle. The performance counters exist only
// when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int NREG = 32,
    parameter int NSRC = 2
);
    localparam int AW = $clog2(NREG);

    logic [NSRC*AW-1:0] rs_d;
    logic [NSRC*AW-1:0] rs_e;
    logic [AW-1:0]      rd_e;
    logic [AW-1:0]      rd_m;
    logic [AW-1:0]      rd_w;
    logic               regwrite_m;
    logic               regwrite_w;
    logic               memread_e;
    logic               md_op_d;
    logic               md_issue_e;
    logic [AW-1:0]      md_rd_e;
    logic               md_done;
    logic               pcsrc_e;
    logic [NSRC*2-1:0]  fwd_e;
    logic               stall_f;
    logic               stall_d;
    logic               flush_d;
    logic               flush_e;
    logic               md_busy;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0]        stall_cnt;
    logic [31:0]        flush_cnt;
`endif

    modport master (
        output rs_d, rs_e, rd_e, rd_m, rd_w, regwrite_m, regwrite_w, memread_e,
               md_op_d, md_issue_e, md_rd_e, md_done, pcsrc_e,
        input  fwd_e, stall_f, stall_d, flush_d, flush_e, md_busy
`ifdef PIPE_HAZARD_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  rs_d, rs_e, rd_e, rd_m, rd_w, regwrite_m, regwrite_w, memread_e,
               md_op_d, md_issue_e, md_rd_e, md_done, pcsrc_e,
        output fwd_e, stall_f, stall_d, flush_d, flush_e, md_busy
`ifdef PIPE_HAZARD_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_scoreboard.sv
// One-entry scoreboard for the non-pipelined mul/div unit: tracks the outstanding
// destination and raises mdh for dependent or structurally conflicting D instructions.
module md_scoreboard_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic md_issue_e
);
    // The unit is non-pipelined, so a second launch while busy is illegal.
    a_no_issue_while_busy: assert property (@(posedge clk) disable iff (rst) !(busy && md_issue_e));
endmodule

module md_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NSRC = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NSRC*$clog2(NREG)-1:0]  rs_d,
    input  logic                          md_op_d,
    input  logic                          md_issue_e,
    input  logic [$clog2(NREG)-1:0]       md_rd_e,
    input  logic                          md_done,
    input  logic                          flush_e,
    output logic                          mdh,
    output logic                          md_busy
);
    localparam int AW = $clog2(NREG);

    md_state_e         state_r;
    logic [AW-1:0]     busy_rd_r;
    logic              md_busy_r;
    logic [NSRC-1:0]   hit_s;
    logic              rd_nz_s;
    logic              waw_s;
    logic              mdh_s;

    for (genvar k = 0; k < NSRC; k++) begin : g_hit
        assign hit_s[k] = (rs_d[k*AW +: AW] == busy_rd_r);
    end

    assign rd_nz_s = (busy_rd_r != {AW{1'b0}});
    // A mul/div in D carries its destination in slot 0.
    assign waw_s   = md_op_d && (rs_d[AW-1:0] == busy_rd_r);

    // Scoreboard state, outstanding destination and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            busy_rd_r <= {AW{1'b0}};
            md_busy_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (md_issue_e && !flush_e) begin
                        state_r   <= BUSY;
                        busy_rd_r <= md_rd_e;
                        md_busy_r <= 1'b1;
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        state_r   <= IDLE;
                        md_busy_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    md_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Hazard holds through the md_done cycle since the state is still BUSY then.
    always_comb begin
        mdh_s = 1'b0;
        if (state_r == BUSY) begin
            mdh_s = md_op_d || (rd_nz_s && ((|hit_s) || waw_s));
        end else begin
            mdh_s = 1'b0;
        end
    end

    assign mdh     = mdh_s;
    assign md_busy = md_busy_r;

    md_scoreboard_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .busy       (state_r == BUSY),
        .md_issue_e (md_issue_e)
    );

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: forwarding selects, load-use and
// mul/div stalls, branch flushes. PIPE_HAZARD_PERF_EN adds stall/flush cycle counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NSRC = 2
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hif
);
    localparam int AW = $clog2(NREG);

    logic [NSRC*2-1:0] fwd_s;
    logic [NSRC-1:0]   lu_hit_s;
    logic              lu_s;
    logic              mdh_s;
    logic              md_busy_s;
    logic              stall_s;
    logic              flush_e_s;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [AW-1:0] rs_e_k_s;
        logic          hit_m_s;
        logic          hit_w_s;
        assign rs_e_k_s = hif.rs_e[k*AW +: AW];
        assign hit_m_s  = hif.regwrite_m && (hif.rd_m != {AW{1'b0}}) && (rs_e_k_s == hif.rd_m);
        assign hit_w_s  = hif.regwrite_w && (hif.rd_w != {AW{1'b0}}) && (rs_e_k_s == hif.rd_w);
        assign fwd_s[k*2 +: 2] = fwd_pick(hit_m_s, hit_w_s);
        assign lu_hit_s[k]     = (hif.rs_d[k*AW +: AW] == hif.rd_e);
    end

    assign lu_s = hif.memread_e && (hif.rd_e != {AW{1'b0}}) && (|lu_hit_s);

    md_scoreboard #(
        .NREG (NREG),
        .NSRC (NSRC)
    ) u_md_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rs_d       (hif.rs_d),
        .md_op_d    (hif.md_op_d),
        .md_issue_e (hif.md_issue_e),
        .md_rd_e    (hif.md_rd_e),
        .md_done    (hif.md_done),
        .flush_e    (flush_e_s),
        .mdh        (mdh_s),
        .md_busy    (md_busy_s)
    );

    // A resolved branch beats any stall: the D instruction is on the wrong path.
    assign stall_s   = (lu_s || mdh_s) && !hif.pcsrc_e;
    assign flush_e_s = lu_s || mdh_s || hif.pcsrc_e;

    assign hif.fwd_e   = fwd_s;
    assign hif.stall_f = stall_s;
    assign hif.stall_d = stall_s;
    assign hif.flush_d = hif.pcsrc_e;
    assign hif.flush_e = flush_e_s;
    assign hif.md_busy = md_busy_s;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running wrap-around counters of stall and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + {31'd0, stall_s};
            flush_cnt_r <= flush_cnt_r + {31'd0, hif.pcsrc_e};
        end
    end

    assign hif.stall_cnt = stall_cnt_r;
    assign hif.flush_cnt = flush_cnt_r;
`endif

endmodule
